key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream input-conditioning stage for the pushbutton path. Takes raw, asynchronous, bouncing board keys and produces clean per-key signals for the oneshot stage:
  - a debounced level,
  - a 1-clk press pulse,
  - a 1-clk release pulse.
- key_level[i] drives a oneshot's ina directly. key_press[i] serves logic that needs a single edge event.
- All keys are handled independently with identical logic.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- STABLE_BITS, 20: width of the dwell counter. The input must be stable for 2^STABLE_BITS clk cycles to be accepted; 2^20 is about 21 ms at 50 MHz.
- ACTIVE_LOW, 1: 1 means key_raw reads 0 when pressed (board KEYs); 0 means key_raw reads 1 when pressed.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset, input, 1: synchronous, active-high reset.
- key_raw, input, NUM_KEYS: raw asynchronous key pins.
- key_level, output, NUM_KEYS: debounced state, 1 = pressed. Registered.
- key_press, output, NUM_KEYS: 1-clk pulse on accepted press. Registered.
- key_release, output, NUM_KEYS: 1-clk pulse on accepted release. Registered.

Behaviour:
- Synchronizer: 2-flop chain per key. Polarity is normalised after it: sample = sync2 XOR ACTIVE_LOW, with 1 = pressed.
- Per-channel FSM, 4 states:
  - IDLE (stable released): sample=1 -> CHK_PRESS, cnt<=0.
  - CHK_PRESS: sample=0 -> IDLE, cnt<=0. sample=1 and cnt!=all-ones -> cnt<=cnt+1. sample=1 and cnt==all-ones -> HELD.
  - HELD (stable pressed): sample=0 -> CHK_REL, cnt<=0.
  - CHK_REL: mirror of CHK_PRESS. sample=1 -> HELD. cnt==all-ones and sample=0 -> IDLE.
- Outputs:
  - key_level=1 in HELD and CHK_REL; 0 in IDLE and CHK_PRESS.
  - key_press=1 for exactly the cycle after the CHK_PRESS->HELD transition.
  - key_release=1 for exactly the cycle after the CHK_REL->IDLE transition.
- Latency: key_raw changes before edge k and then holds. key_level and the pulse update at edge k+2+2^STABLE_BITS. With STABLE_BITS=4, that is edge k+18.
- Counter: STABLE_BITS wide, unsigned. It never wraps; it terminates at all-ones. Any disagreeing sample during a CHK state aborts the check, returns to the prior stable state, and emits no pulse.
- Glitch shorter than 2^STABLE_BITS cycles: outputs unchanged.
- Press and release pulses are mutually exclusive per channel. key_level never toggles more than once per 2^STABLE_BITS+1 cycles.
- Simultaneous activity on several keys: fully independent; pulses may coincide across channels.
- Reset: evaluated every clk edge and overrides everything.
  - Sync flops are loaded with the released value (normalised 0).
  - FSM goes to IDLE, cnt=0.
  - key_level, key_press, key_release = 0.
- Reset mid-check: the check is discarded with no pulse. A key still held after reset deasserts goes through a full dwell and then emits key_press. This is required behaviour.
- No combinational path from key_raw to any output.

Decomposition:
- Package key_debounce_pkg holds:
  - the state encoding constants ST_IDLE, ST_CHK_PRESS, ST_HELD, ST_CHK_REL (2-bit);
  - default STABLE_BITS.
- One sub-module, key_debounce_chan, is natural: a single channel containing the synchronizer, FSM, counter and output regs.
- The top instantiates NUM_KEYS copies with a generate loop and handles ACTIVE_LOW normalisation.

Test Plan (STABLE_BITS=4, ACTIVE_LOW=1, NUM_KEYS=4):
1. Reset held 3 cycles, key_raw=4'hF -> all outputs 0. No pulses for 40 cycles after release.
2. key_raw[0] driven 0 before edge k, held -> key_level[0]=1 and key_press[0]=1 at edge k+18. key_press[0]=0 at k+19. key_release stays 0.
3. Bounce: key_raw[1] alternates 0/1 every 3 cycles for 30 cycles, then holds 0 -> exactly one key_press[1] pulse, 18 cycles after the final stable edge. No key_release[1].
4. Release: key 0 held, then key_raw[0]=1 before edge m -> key_level[0]=0 and key_release[0]=1 at edge m+18. Single-cycle pulse.
5. Glitch: key_raw[2]=0 for 10 cycles, then back to 1 -> key_level[2], key_press[2] and key_release[2] all stay 0.
6. Reset mid-operation:
   - reset asserted at cnt=8 in CHK_PRESS with the key still held -> no pulse during reset;
   - after deassert at edge r, key_press fires at edge r+18.
   - Also, keys 0 and 3 pressed on the same edge -> both key_press bits are high in the same cycle.

Source files
------------

// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_pkg
//  Purpose  : Shared state encoding and defaults for the key debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHK_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_CHK_REL   = 2'd3
    } deb_state_t;

    // 2^20 clk cycles is roughly 21 ms at 50 MHz
    localparam int DEFAULT_STABLE_BITS = 20;

endpackage : key_debounce_pkg
`default_nettype wire

// File: rtl/key_debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_chan
//  Purpose  : One key channel: 2-flop synchronizer, dwell FSM, pulse outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int STABLE_BITS = DEFAULT_STABLE_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [STABLE_BITS-1:0] c_CNT_MAX = '1;
    localparam logic [STABLE_BITS-1:0] c_CNT_ONE = {{(STABLE_BITS-1){1'b0}}, 1'b1};

    logic                   r_sync1;
    logic                   r_sync2;
    deb_state_t             r_state;
    logic [STABLE_BITS-1:0] r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    // i_key is already normalised, so the released value is 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2) begin
                        r_state <= ST_CHK_PRESS;
                        r_cnt   <= '0;
                    end
                end
                ST_CHK_PRESS: begin
                    if (!r_sync2) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_state <= ST_HELD;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!r_sync2) begin
                        r_state <= ST_CHK_REL;
                        r_cnt   <= '0;
                    end
                end
                ST_CHK_REL: begin
                    if (r_sync2) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : key_debounce_chan
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Debounces NUM_KEYS raw board keys into level/press/release.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int STABLE_BITS = DEFAULT_STABLE_BITS,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam logic [NUM_KEYS-1:0] c_POL_MASK = {NUM_KEYS{ACTIVE_LOW}};

    // XOR with a constant commutes with the synchronizer, so normalising
    // here lets every channel treat 1 as pressed
    logic [NUM_KEYS-1:0] w_key_norm;
    assign w_key_norm = key_raw ^ c_POL_MASK;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            key_debounce_chan #(
                .STABLE_BITS (STABLE_BITS)
            ) u_chan (
                .clk       (clk),
                .rst       (reset),
                .i_key     (w_key_norm[gi]),
                .o_level   (key_level[gi]),
                .o_press   (key_press[gi]),
                .o_release (key_release[gi])
            );
        end
    endgenerate

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debounce
//  Purpose  : Directed and random checks of key_debounce against a run-length model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int NK    = 4;
    localparam int SB    = 4;
    localparam int DWELL = 1 << SB;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    key_debounce #(
        .NUM_KEYS    (NK),
        .STABLE_BITS (SB),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: level flips once the delayed sample disagrees with it for DWELL+1 samples in a row
    logic [NK-1:0] m_d1, m_d2, m_level, m_press, m_release;
    int            m_run [NK];
    int            cnt_press [NK];
    int            cnt_rel [NK];
    int            cnt_hi [NK];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NK; i++) begin
            cnt_press[i] = 0;
            cnt_rel[i]   = 0;
            cnt_hi[i]    = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                m_press[i]   = 1'b0;
                m_release[i] = 1'b0;
                if (m_d2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DWELL + 1) begin
                        m_level[i] = m_d2[i];
                        if (m_d2[i]) m_press[i] = 1'b1;
                        else         m_release[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = ~key_raw;
        end
        @(negedge clk);
        chk("level", 32'(key_level), 32'(m_level));
        chk("press", 32'(key_press), 32'(m_press));
        chk("release", 32'(key_release), 32'(m_release));
        for (int i = 0; i < NK; i++) begin
            cnt_press[i] += int'(key_press[i]);
            cnt_rel[i]   += int'(key_release[i]);
            cnt_hi[i]    += int'(key_level[i]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int i = 0; i < NK; i++) m_run[i] = 0;
        m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0;
        clr_counts();

        // 1: reset with all keys released, then quiet
        reset   = 1'b1;
        key_raw = 4'hF;
        run(3);
        chk("rst_level", 32'(key_level), 32'h0);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_release", 32'(key_release), 32'h0);
        reset = 1'b0;
        clr_counts();
        run(40);
        chk("quiet_press_cnt", 32'(cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3]), 32'd0);
        chk("quiet_rel_cnt", 32'(cnt_rel[0] + cnt_rel[1] + cnt_rel[2] + cnt_rel[3]), 32'd0);

        // 2: press key 0, accepted at edge k+18
        key_raw[0] = 1'b0;
        run(18);
        chk("k0_level_k17", 32'(key_level[0]), 32'd0);
        cyc();
        chk("k0_level_k18", 32'(key_level[0]), 32'd1);
        chk("k0_press_k18", 32'(key_press[0]), 32'd1);
        cyc();
        chk("k0_press_k19", 32'(key_press[0]), 32'd0);
        chk("k0_release_k19", 32'(key_release[0]), 32'd0);
        run(3);

        // 3: bounce on key 1, then hold pressed
        clr_counts();
        for (int s = 0; s < 10; s++) begin
            key_raw[1] = s[0];
            run(3);
        end
        key_raw[1] = 1'b0;
        run(18);
        chk("k1_bounce_early", 32'(cnt_press[1]), 32'd0);
        cyc();
        chk("k1_press_f18", 32'(key_press[1]), 32'd1);
        run(5);
        chk("k1_press_cnt", 32'(cnt_press[1]), 32'd1);
        chk("k1_rel_cnt", 32'(cnt_rel[1]), 32'd0);

        // 4: release key 0
        key_raw[0] = 1'b1;
        run(18);
        chk("k0_level_m17", 32'(key_level[0]), 32'd1);
        cyc();
        chk("k0_level_m18", 32'(key_level[0]), 32'd0);
        chk("k0_release_m18", 32'(key_release[0]), 32'd1);
        cyc();
        chk("k0_release_m19", 32'(key_release[0]), 32'd0);

        // 5: short glitch on key 2
        clr_counts();
        key_raw[2] = 1'b0;
        run(10);
        key_raw[2] = 1'b1;
        run(30);
        chk("k2_glitch_hi", 32'(cnt_hi[2]), 32'd0);
        chk("k2_glitch_press", 32'(cnt_press[2]), 32'd0);
        chk("k2_glitch_rel", 32'(cnt_rel[2]), 32'd0);

        // 6: reset during a press check on key 3 (cnt=8), key 1 still held
        key_raw[3] = 1'b0;
        run(11);
        reset = 1'b1;
        clr_counts();
        run(2);
        chk("midrst_pulses", 32'(cnt_press[3] + cnt_rel[3] + cnt_rel[1]), 32'd0);
        chk("midrst_level", 32'(key_level), 32'h0);
        reset = 1'b0;
        run(18);
        chk("r_press_early", 32'(cnt_press[3] + cnt_press[1]), 32'd0);
        cyc();
        chk("r_press_r18", 32'(key_press), 32'b1010);

        // keys 0 and 3 pressed on the same edge
        key_raw = 4'hF;
        run(25);
        key_raw = 4'b0110;
        run(18);
        chk("dual_press_early", 32'(key_press), 32'h0);
        cyc();
        chk("dual_press", 32'(key_press), 32'b1001);
        key_raw = 4'hF;
        run(25);

        // random bouncing on all keys, occasional reset
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(0, (c < 300) ? 15 : 40) == 0) key_raw[i] = ~key_raw[i];
            end
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        run(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire
